// File: rtl/load_use_stall_pkg.sv
// Shared definitions for the load-use / divide hazard unit:
// default divider latency, divider FSM encoding and the hard-wired zero register.
package load_use_stall_pkg;

  localparam int         DIV_LAT_DEFAULT = 32;
  localparam logic [4:0] REG_ZERO        = 5'd0;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_t;

endpackage

// File: rtl/load_use_stall_hazard_div_tracker.sv
// Divider occupancy tracker: a two-state FSM with an 8-bit down-counter.
// A start seen in DIV_IDLE occupies the divider for DIV_LAT cycles; done
// pulses in the last occupied cycle. Reset aborts a divide without a pulse.
module hazard_div_tracker
  import load_use_stall_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam logic [7:0] CNT_INIT = 8'(DIV_LAT - 1);

  div_state_t state_reg;
  logic [7:0] cnt_reg;

  // Divider FSM: accept in idle, count down while busy, leave after cnt hits zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= DIV_IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      case (state_reg)
        DIV_IDLE: begin
          if (start) begin
            state_reg <= DIV_BUSY;
            cnt_reg   <= CNT_INIT;
          end
        end
        DIV_BUSY: begin
          if (cnt_reg == 8'd0) begin
            state_reg <= DIV_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end
        default: begin
          state_reg <= DIV_IDLE;
          cnt_reg   <= 8'd0;
        end
      endcase
    end
  end

  // Outputs are pure decodes of the registered state, so they carry no input path.
  assign busy = (state_reg == DIV_BUSY);
  assign done = (state_reg == DIV_BUSY) && (cnt_reg == 8'd0);

endmodule

// File: rtl/load_use_stall.sv
// Load-use and divider hazard detection for a 5-stage pipeline.
// A load result is not forwardable, so any capable ID source matching a load
// in EX or MEM stalls; divides and HI-LO readers stall while the divider is busy.
// Optional feature: define HAZARD_PERF_EN to add the saturating stall_cycles counter.
module load_use_stall
  import load_use_stall_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_raddr1,
  input  logic [4:0] id_raddr2,
  input  logic       id_re1,
  input  logic       id_re2,
  input  logic       id_valid,
  input  logic       id_is_div,
  input  logic       id_uses_hilo,
  input  logic       ex_reg_wr,
  input  logic       ex_mem_rd,
  input  logic [4:0] ex_waddr,
  input  logic       mem_reg_wr,
  input  logic       mem_mem_rd,
  input  logic [4:0] mem_waddr,
  output logic       stall,
  output logic       bubble,
  output logic       div_busy,
  output logic       div_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  logic [4:0] raddr [2];
  logic [1:0] re;
  logic [1:0] src_hz;
  logic       ld_hz;
  logic       dv_hz;
  logic       hz;
  logic       div_start;

  assign raddr[0] = id_raddr1;
  assign raddr[1] = id_raddr2;
  assign re       = {id_re2, id_re1};

  // Per-source load-use check; register zero is never a dependency.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_hz[gi] = re[gi] && (raddr[gi] != REG_ZERO) &&
                        ((ex_reg_wr  && ex_mem_rd  && (raddr[gi] == ex_waddr)) ||
                         (mem_reg_wr && mem_mem_rd && (raddr[gi] == mem_waddr)));
  end

  assign ld_hz  = id_valid && (|src_hz);
  assign dv_hz  = div_busy && id_valid && (id_is_div || id_uses_hilo);
  assign hz     = ld_hz || dv_hz;
  assign stall  = hz;
  assign bubble = hz;

  // A held divide is not issued; it is retried each cycle until the stall clears.
  assign div_start = id_valid && id_is_div && !hz;

  hazard_div_tracker #(
    .DIV_LAT (DIV_LAT)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .busy  (div_busy),
    .done  (div_done)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_reg;

  // Count stalled cycles, pinning at the maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_reg <= 32'd0;
    end else if (hz && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: doc/load_use_stall.md
LOAD_USE_STALL -- requirements
Module: load_use_stall

Interface
REQ-001 SHALL have parameter DIV_LAT, default 32, meaning divider occupancy in cycles (legal 2..255).
REQ-002 SHALL have port clk  input  1  the single pipeline clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports id_raddr1, id_raddr2  input  5 each  ID-stage source register numbers.
REQ-005 SHALL have ports id_re1, id_re2  input  1 each  ID actually reads the matching source.
REQ-006 SHALL have ports id_valid, id_is_div, id_uses_hilo  input  1 each  ID holds a real instruction / a divide / a HI-LO reader.
REQ-007 SHALL have ports ex_reg_wr, ex_mem_rd  input  1 each, and ex_waddr  input  5  EX-stage writer, load flag and destination.
REQ-008 SHALL have ports mem_reg_wr, mem_mem_rd  input  1 each, and mem_waddr  input  5  MEM-stage equivalents.
REQ-009 SHALL have port stall  output  1  hold PC and IF/ID.
REQ-010 SHALL have port bubble  output  1  flush ID/EX to a NOP.
REQ-011 SHALL have ports div_busy and div_done  output  1 each  divider occupied / one-cycle completion pulse.

Function
REQ-012 SHALL treat a source as hazard-capable only if re=1 and raddr!=0; register 0 never stalls.
REQ-013 SHALL assert ld_hz combinationally when id_valid=1 and a capable source equals ex_waddr with ex_reg_wr=1 and ex_mem_rd=1, or equals mem_waddr with mem_reg_wr=1 and mem_mem_rd=1, because the forwarding path carries ALU results only.
REQ-014 SHALL therefore stall a load consumer 2 cycles if the load is in EX and 1 cycle if it is in MEM.
REQ-015 SHALL assert dv_hz when state=DIV_BUSY and id_valid=1 and (id_is_div=1 or id_uses_hilo=1).
REQ-016 SHALL drive stall = bubble = ld_hz | dv_hz, with no added latency.
REQ-017 SHALL implement states DIV_IDLE and DIV_BUSY with an 8-bit down-counter cnt.
REQ-018 SHALL, in DIV_IDLE with id_valid=1, id_is_div=1 and stall=0, load cnt=DIV_LAT-1 and enter DIV_BUSY at the next edge.
REQ-019 SHALL not accept a divide while stall=1; the divide is re-evaluated each held cycle.
REQ-020 SHALL, in DIV_BUSY, decrement cnt each cycle; when cnt=0, assert div_done for that cycle and return to DIV_IDLE at the next edge.
REQ-021 SHALL drive div_busy=1 exactly while state=DIV_BUSY; for a divide accepted in cycle N, it is high in cycles N+1..N+DIV_LAT and div_done is high in cycle N+DIV_LAT only.
REQ-022 SHALL keep a HI-LO reader stalled through the div_done cycle and release it in the following cycle.
REQ-023 SHALL, when ld_hz and dv_hz coincide, assert stall once; the divider keeps counting.

Reset
REQ-024 SHALL, with rst=1 at an edge, force state=DIV_IDLE and cnt=0, including an abort in the middle of a divide.
REQ-025 SHALL hold div_busy=0 and div_done=0 in the cycle after reset, with no completion pulse for an aborted divide.
REQ-026 SHALL derive stall and bubble only from inputs and reset state after reset.

Configuration
REQ-027 SHALL, with HAZARD_PERF_EN defined, add port stall_cycles  output  32, reset to 0, incremented each cycle stall=1 and saturating at 32'hFFFFFFFF.
REQ-028 SHALL, without HAZARD_PERF_EN, omit the stall_cycles port and its register, with all other behaviour identical.

Structure
REQ-029 SHALL place the DIV_LAT default, the DIV_IDLE/DIV_BUSY encoding and the REG_ZERO=5'd0 constant in the shared definitions header.
REQ-030 SHALL isolate the divide FSM and counter in sub-module hazard_div_tracker (inputs: start, clk, rst; outputs: busy, done); load detection stays in the top level.

Verification
REQ-031 SHALL check: ex load $t0=8, ID reads raddr1=8 (re1=1) -> stall=bubble=1 for 2 cycles as the load moves EX->MEM, then 0.
REQ-032 SHALL check: ex ALU write (ex_mem_rd=0) waddr=8, ID reads 8 -> stall=0; and ex load waddr=0, ID reads 0 -> stall=0.
REQ-033 SHALL check: with DIV_LAT=4, divide accepted in cycle 10 -> div_busy high in cycles 11-14, div_done only in 14, id_uses_hilo stall held through 14, released in 15.
REQ-034 SHALL check: divide in ID while an EX load hazards its source -> not accepted (div_busy stays 0) until the stall clears, then accepted.
REQ-035 SHALL check: rst=1 in cycle 3 of a DIV_LAT=8 divide -> div_busy=0 next cycle and no div_done pulse at any later cycle.
REQ-036 SHALL check, with HAZARD_PERF_EN: 5 stall cycles -> stall_cycles=5; preset near 32'hFFFFFFFF -> value saturates and does not wrap.
